// File: rtl/tiny1_mmio_hub.sv
// tiny1_mmio_hub
//   Memory-mapped I/O hub between the tiny1 core memory port and the SoC
//   RAM / UART / LED resources. mem_addr[15] steers an access either to RAM
//   (strobes passed straight through) or to the hub register file indexed by
//   mem_addr[10:0]. The hub adds RX/TX byte FIFOs in front of the UART, an
//   LED register, sticky overflow flags and a maskable, acknowledgeable IRQ.
//
// Ports
//   clk, rst            system clock; synchronous active-low reset
//   mem_addr            core address (bit 15 = mmio, [10:0] = register index)
//   mem_data_o          core write data
//   mem_wr, mem_rd      core write / read strobes
//   mem_data_i          read data returned to the core
//   ram_data_i          RAM read data
//   ram_we, ram_re      RAM strobes (core strobes when bit 15 clear)
//   uart_din            received UART byte, valid while uart_valid
//   uart_valid          UART holds a received byte
//   uart_ready          UART transmitter idle
//   uart_rd             one-cycle pulse consuming uart_din
//   uart_wr             one-cycle pulse sending uart_out
//   uart_out            byte to transmit (holds last sent byte)
//   irq, irqack         interrupt request / acknowledge
//   leds                LED register
module tiny1_mmio_hub #(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int GPIO_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_data_o,
  input  logic              mem_wr,
  input  logic              mem_rd,
  output logic [15:0]       mem_data_i,
  input  logic [15:0]       ram_data_i,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        uart_din,
  input  logic              uart_valid,
  input  logic              uart_ready,
  output logic              uart_rd,
  output logic              uart_wr,
  output logic [7:0]        uart_out,
  output logic              irq,
  input  logic              irqack,
  output logic [GPIO_W-1:0] leds
);

  localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int RX_CW = RX_AW + 1;
  localparam int TX_CW = TX_AW + 1;

  localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);

  localparam logic [10:0] REG_STATUS   = 11'd0;
  localparam logic [10:0] REG_RX_DATA  = 11'd1;
  localparam logic [10:0] REG_TX_DATA  = 11'd2;
  localparam logic [10:0] REG_LEDS     = 11'd3;
  localparam logic [10:0] REG_IRQ_EN   = 11'd4;
  localparam logic [10:0] REG_RX_COUNT = 11'd5;
  localparam logic [10:0] REG_TX_COUNT = 11'd6;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_HOLD
  } tx_state_t;

  rx_state_t        rx_state;
  tx_state_t        tx_state;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr;
  logic [RX_AW-1:0] rx_rptr;
  logic [RX_CW-1:0] rx_count;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr;
  logic [TX_AW-1:0] tx_rptr;
  logic [TX_CW-1:0] tx_count;

  logic             rx_ovf;
  logic             tx_ovf;
  logic [2:0]       irq_en;
  logic             ack_hold_p0;

  logic [15:0]      rd_data_p0;
  logic             rd_mmio_p0;
  logic [15:0]      rd_mux;

  logic             mmio;
  logic [10:0]      reg_idx;
  logic             mmio_rd;
  logic             mmio_wr;
  logic             rx_nonempty;
  logic             rx_full;
  logic             tx_empty;
  logic             tx_full;
  logic             rx_pop;
  logic             rx_push;
  logic             rx_drop;
  logic             tx_push;
  logic             tx_drop;
  logic             tx_pop;
  logic             sts_wr;
  logic             irq_cond;
  logic             unused_bits;

  assign mmio    = mem_addr[15];
  assign reg_idx = mem_addr[10:0];
  assign mmio_rd = mem_rd & mmio;
  assign mmio_wr = mem_wr & mmio;

  assign ram_we = mem_wr & ~mmio;
  assign ram_re = mem_rd & ~mmio;

  assign unused_bits = ^{mem_addr[14:11], mem_data_o[15:8]};

  assign rx_nonempty = (rx_count != '0);
  assign rx_full     = (rx_count == RX_FULL_CNT);
  assign tx_empty    = (tx_count == '0);
  assign tx_full     = (tx_count == TX_FULL_CNT);

  // Both FSM strobes are decoded from state and gated by reset so that a
  // reset cycle never emits a UART handshake, even mid-transfer.
  assign uart_rd = rst & (rx_state == RX_IDLE) & uart_valid;
  assign uart_wr = rst & (tx_state == TX_SEND);

  assign rx_pop  = mmio_rd & (reg_idx == REG_RX_DATA) & rx_nonempty;
  // A full RX FIFO still accepts the byte when a pop frees a slot this cycle.
  assign rx_push = uart_rd & (~rx_full | rx_pop);
  assign rx_drop = uart_rd & rx_full & ~rx_pop;

  assign tx_push = mmio_wr & (reg_idx == REG_TX_DATA) & ~tx_full;
  assign tx_drop = mmio_wr & (reg_idx == REG_TX_DATA) & tx_full;
  assign tx_pop  = uart_wr & ~tx_empty;

  assign sts_wr  = mmio_wr & (reg_idx == REG_STATUS);

  assign irq_cond = (rx_nonempty & irq_en[0]) |
                    (tx_empty & irq_en[1]) |
                    ((rx_ovf | tx_ovf) & irq_en[2]);

  // RX FIFO
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= uart_din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: ;
      endcase
    end
  end

  // TX FIFO
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= mem_data_o[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: ;
      endcase
    end
  end

  // RX drain FSM: one byte per visit to IDLE, ACK lets uart_valid fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: if (uart_valid) rx_state <= RX_ACK;
        RX_ACK:  rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // TX FSM: uart_out is loaded on the way into SEND so it is stable for the
  // whole uart_wr cycle and then holds the last byte sent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      uart_out <= 8'h00;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (!tx_empty && uart_ready) begin
            tx_state <= TX_SEND;
            uart_out <= tx_mem[tx_rptr];
          end
        end
        TX_SEND: tx_state <= TX_HOLD;
        TX_HOLD: tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Sticky overflow flags; a new overflow in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (sts_wr && mem_data_o[2]) rx_ovf <= 1'b0;
      if (rx_drop)                 rx_ovf <= 1'b1;
      if (sts_wr && mem_data_o[3]) tx_ovf <= 1'b0;
      if (tx_drop)                 tx_ovf <= 1'b1;
    end
  end

  // Writable control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      leds   <= '0;
      irq_en <= 3'b000;
    end else begin
      if (mmio_wr && reg_idx == REG_LEDS)   leds   <= mem_data_o[GPIO_W-1:0];
      if (mmio_wr && reg_idx == REG_IRQ_EN) irq_en <= mem_data_o[2:0];
    end
  end

  // IRQ: an ack forces irq low for the ack cycle and the one after it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq         <= 1'b0;
      ack_hold_p0 <= 1'b0;
    end else begin
      ack_hold_p0 <= irqack;
      irq         <= (irqack || ack_hold_p0) ? 1'b0 : irq_cond;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      REG_STATUS:   rd_mux[4:0] = {irq, tx_ovf, rx_ovf, ~tx_full, rx_nonempty};
      REG_RX_DATA:  if (rx_nonempty) rd_mux[7:0] = rx_mem[rx_rptr];
      REG_LEDS:     rd_mux[GPIO_W-1:0] = leds;
      REG_IRQ_EN:   rd_mux[2:0] = irq_en;
      REG_RX_COUNT: rd_mux[RX_CW-1:0] = rx_count;
      REG_TX_COUNT: rd_mux[TX_CW-1:0] = tx_count;
      default:      ;
    endcase
  end

  // Read stage p0: register the mmio data and the steering flag of the read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_p0 <= 16'h0000;
      rd_mmio_p0 <= 1'b0;
    end else if (mem_rd) begin
      rd_mmio_p0 <= mmio;
      if (mmio) rd_data_p0 <= rd_mux;
    end
  end

  assign mem_data_i = rd_mmio_p0 ? rd_data_p0 : ram_data_i;

endmodule

// File: tb/tb_tiny1_mmio_hub.sv
module tb_tiny1_mmio_hub;

  localparam int RX_DEPTH = 8;
  localparam int TX_DEPTH = 8;
  localparam int GPIO_W   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       mem_addr = '0;
  logic [15:0]       mem_data_o = '0;
  logic              mem_wr = 1'b0;
  logic              mem_rd = 1'b0;
  logic [15:0]       mem_data_i;
  logic [15:0]       ram_data_i = '0;
  logic              ram_we;
  logic              ram_re;
  logic [7:0]        uart_din = '0;
  logic              uart_valid = 1'b0;
  logic              uart_ready = 1'b0;
  logic              uart_rd;
  logic              uart_wr;
  logic [7:0]        uart_out;
  logic              irq;
  logic              irqack = 1'b0;
  logic [GPIO_W-1:0] leds;

  always #5 clk = ~clk;

  tiny1_mmio_hub #(.RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .GPIO_W(GPIO_W)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_data_i(mem_data_i), .ram_data_i(ram_data_i), .ram_we(ram_we), .ram_re(ram_re),
    .uart_din(uart_din), .uart_valid(uart_valid), .uart_ready(uart_ready),
    .uart_rd(uart_rd), .uart_wr(uart_wr), .uart_out(uart_out),
    .irq(irq), .irqack(irqack), .leds(leds)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: FIFO contents as queues plus the sticky flags.
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         m_rx_ovf = 0;
  bit         m_tx_ovf = 0;

  function automatic logic [15:0] exp_status(input bit irq_exp);
    return {11'b0, irq_exp, m_tx_ovf, m_rx_ovf, (tx_q.size() < TX_DEPTH), (rx_q.size() != 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [10:0] idx, input logic [15:0] d);
    mem_addr = {1'b1, 4'b0000, idx};
    mem_data_o = d;
    mem_wr = 1'b1;
    tick();
    mem_wr = 1'b0;
    mem_addr = '0;
    if (idx == 11'd2) begin
      if (tx_q.size() < TX_DEPTH) tx_q.push_back(d[7:0]);
      else m_tx_ovf = 1;
    end
    if (idx == 11'd0) begin
      if (d[2]) m_rx_ovf = 0;
      if (d[3]) m_tx_ovf = 0;
    end
  endtask

  task automatic bus_read(input logic [10:0] idx, output logic [15:0] d);
    mem_addr = {1'b1, 4'b0000, idx};
    mem_rd = 1'b1;
    tick();
    mem_rd = 1'b0;
    mem_addr = '0;
    d = mem_data_i;
  endtask

  task automatic rx_expect(output logic [15:0] e);
    if (rx_q.size() != 0) e = {8'h00, rx_q.pop_front()};
    else e = 16'h0000;
  endtask

  task automatic uart_send(input logic [7:0] b, output logic rd_seen);
    uart_din = b;
    uart_valid = 1'b1;
    #1;
    rd_seen = uart_rd;
    @(posedge clk);
    #1;
    uart_valid = 1'b0;
    tick();
    if (rx_q.size() < RX_DEPTH) rx_q.push_back(b);
    else m_rx_ovf = 1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    uart_valid = 1'b1;
    uart_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (uart_rd !== 1'b0) begin failures++; $display("FAIL reset_uart_rd: got %b want 0", uart_rd); end
    checks++; if (uart_wr !== 1'b0) begin failures++; $display("FAIL reset_uart_wr: got %b want 0", uart_wr); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++; if (leds !== '0) begin failures++; $display("FAIL reset_leds: got %h want 0", leds); end
    uart_valid = 1'b0;
    uart_ready = 1'b0;
    rst = 1'b1;
    tick();
    begin
      logic [15:0] d;
      bus_read(11'd0, d);
      checks++; if (d !== 16'h0002) begin failures++; $display("FAIL reset_status: got %h want 0002", d); end
      checks++; if (uart_out !== 8'h00) begin failures++; $display("FAIL reset_uart_out: got %h want 00", uart_out); end
    end
  endtask

  task automatic test_rx_basic();
    logic [15:0] d, e;
    logic seen;
    logic [7:0] bytes [3];
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
    for (int i = 0; i < 3; i++) begin
      uart_send(bytes[i], seen);
      checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rx_uart_rd: got %b want 1 (byte %0d)", seen, i); end
    end
    bus_read(11'd5, d);
    checks++; if (d !== 16'(rx_q.size())) begin failures++; $display("FAIL rx_count3: got %h want %h", d, 16'(rx_q.size())); end
    for (int i = 0; i < 4; i++) begin
      bus_read(11'd1, d);
      rx_expect(e);
      checks++; if (d !== e) begin failures++; $display("FAIL rx_data%0d: got %h want %h", i, d, e); end
    end
    bus_read(11'd0, d);
    checks++; if (d !== exp_status(0)) begin failures++; $display("FAIL rx_empty_status: got %h want %h", d, exp_status(0)); end
  endtask

  task automatic test_rx_overflow();
    logic [15:0] d, e;
    logic seen;
    for (int i = 0; i < RX_DEPTH + 2; i++) uart_send(8'($urandom), seen);
    bus_read(11'd5, d);
    checks++; if (d !== 16'(RX_DEPTH)) begin failures++; $display("FAIL rx_ovf_count: got %h want %h", d, 16'(RX_DEPTH)); end
    bus_read(11'd0, d);
    checks++; if (d !== exp_status(0)) begin failures++; $display("FAIL rx_ovf_status: got %h want %h", d, exp_status(0)); end
    bus_write(11'd0, 16'h0004);
    bus_read(11'd0, d);
    checks++; if (d !== exp_status(0)) begin failures++; $display("FAIL rx_ovf_clear: got %h want %h", d, exp_status(0)); end
    for (int i = 0; i < RX_DEPTH; i++) begin
      bus_read(11'd1, d);
      rx_expect(e);
      checks++; if (d !== e) begin failures++; $display("FAIL rx_ovf_data%0d: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_tx_overflow();
    logic [15:0] d;
    int pulses;
    logic prev;
    logic [7:0] e;
    uart_ready = 1'b0;
    for (int i = 0; i < TX_DEPTH + 1; i++) bus_write(11'd2, 16'($urandom));
    bus_read(11'd6, d);
    checks++; if (d !== 16'(TX_DEPTH)) begin failures++; $display("FAIL tx_count_full: got %h want %h", d, 16'(TX_DEPTH)); end
    bus_read(11'd0, d);
    checks++; if (d !== exp_status(0)) begin failures++; $display("FAIL tx_ovf_status: got %h want %h", d, exp_status(0)); end
    uart_ready = 1'b1;
    pulses = 0;
    prev = 1'b0;
    for (int c = 0; c < TX_DEPTH * 4 + 16; c++) begin
      tick();
      if (uart_wr === 1'b1) begin
        pulses++;
        e = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hxx;
        checks++; if (uart_out !== e) begin failures++; $display("FAIL tx_byte%0d: got %h want %h", pulses, uart_out, e); end
        checks++; if (prev !== 1'b0) begin failures++; $display("FAIL tx_pulse_width: got wide pulse at byte %0d want 1 cycle", pulses); end
      end
      prev = uart_wr;
    end
    uart_ready = 1'b0;
    checks++; if (pulses != TX_DEPTH) begin failures++; $display("FAIL tx_pulses: got %0d want %0d", pulses, TX_DEPTH); end
    bus_write(11'd0, 16'h0008);
    bus_read(11'd0, d);
    checks++; if (d !== exp_status(0)) begin failures++; $display("FAIL tx_ovf_clear: got %h want %h", d, exp_status(0)); end
  endtask

  task automatic test_irq();
    logic [15:0] d, e;
    logic seen;
    bus_write(11'd4, 16'h0001);
    bus_read(11'd4, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL irq_en_rb: got %h want 0001", d); end
    uart_send(8'($urandom), seen);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx_assert: got %b want 1", irq); end
    irqack = 1'b1;
    tick();
    irqack = 1'b0;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_ack_c1: got %b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_ack_c2: got %b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_reassert: got %b want 1", irq); end
    bus_read(11'd1, d);
    rx_expect(e);
    checks++; if (d !== e) begin failures++; $display("FAIL irq_rx_data: got %h want %h", d, e); end
    irqack = 1'b1;
    tick();
    irqack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_stays_low%0d: got %b want 0", i, irq); end
      tick();
    end
    bus_write(11'd4, 16'h0002);
    tick();
    bus_read(11'd0, d);
    checks++; if (d !== exp_status(1)) begin failures++; $display("FAIL irq_tx_empty_status: got %h want %h", d, exp_status(1)); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx_empty: got %b want 1", irq); end
    bus_write(11'd4, 16'h0000);
    tick(); tick();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_disabled: got %b want 0", irq); end
  endtask

  task automatic test_leds_ram();
    logic [15:0] d, r;
    bus_write(11'd3, 16'h00A5);
    checks++; if (leds !== 8'hA5) begin failures++; $display("FAIL leds_a5: got %h want a5", leds); end
    bus_read(11'd3, d);
    checks++; if (d !== 16'h00A5) begin failures++; $display("FAIL leds_rb: got %h want 00a5", d); end
    mem_addr = 16'h8003;
    mem_data_o = 16'hFF5A;
    mem_wr = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL mmio_no_ram_we: got %b want 0", ram_we); end
    tick();
    mem_wr = 1'b0;
    checks++; if (leds !== 8'h5A) begin failures++; $display("FAIL leds_trunc: got %h want 5a", leds); end
    mem_addr = 16'h0003;
    mem_data_o = 16'h1234;
    mem_wr = 1'b1;
    #1;
    checks++; if ({ram_we, ram_re} !== 2'b10) begin failures++; $display("FAIL ram_we: got %b want 10", {ram_we, ram_re}); end
    tick();
    mem_wr = 1'b0;
    checks++; if (leds !== 8'h5A) begin failures++; $display("FAIL ram_no_side_effect: got %h want 5a", leds); end
    r = 16'($urandom);
    ram_data_i = r;
    mem_addr = 16'h0001;
    mem_rd = 1'b1;
    #1;
    checks++; if ({ram_we, ram_re} !== 2'b01) begin failures++; $display("FAIL ram_re: got %b want 01", {ram_we, ram_re}); end
    tick();
    mem_rd = 1'b0;
    checks++; if (mem_data_i !== r) begin failures++; $display("FAIL ram_passthrough: got %h want %h", mem_data_i, r); end
    mem_addr = '0;
  endtask

  task automatic test_random();
    logic [15:0] d, e;
    logic seen;
    int op;
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: uart_send(8'($urandom), seen);
        2: begin
          bus_read(11'd1, d);
          rx_expect(e);
          checks++; if (d !== e) begin failures++; $display("FAIL rand_rx_data it%0d: got %h want %h", i, d, e); end
        end
        3: begin
          bus_read(11'd5, d);
          checks++; if (d !== 16'(rx_q.size())) begin failures++; $display("FAIL rand_rx_count it%0d: got %h want %h", i, d, 16'(rx_q.size())); end
        end
        4: begin
          bus_read(11'd0, d);
          checks++; if (d !== exp_status(0)) begin failures++; $display("FAIL rand_status it%0d: got %h want %h", i, d, exp_status(0)); end
        end
        default: bus_write(11'd0, 16'h0004);
      endcase
    end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] d;
    uart_ready = 1'b0;
    bus_write(11'd2, 16'h0011);
    bus_write(11'd2, 16'h0022);
    uart_ready = 1'b1;
    tick();
    checks++; if (uart_wr !== 1'b1) begin failures++; $display("FAIL mid_tx_start: got %b want 1", uart_wr); end
    rst = 1'b0;
    uart_valid = 1'b1;
    #1;
    checks++; if ({uart_wr, uart_rd} !== 2'b00) begin failures++; $display("FAIL mid_reset_strobes: got %b want 00", {uart_wr, uart_rd}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({uart_wr, uart_rd} !== 2'b00) begin failures++; $display("FAIL mid_reset_hold%0d: got %b want 00", i, {uart_wr, uart_rd}); end
    end
    uart_valid = 1'b0;
    uart_ready = 1'b0;
    rst = 1'b1;
    rx_q.delete();
    tx_q.delete();
    m_rx_ovf = 0;
    m_tx_ovf = 0;
    tick();
    bus_read(11'd6, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL mid_tx_count: got %h want 0000", d); end
    bus_read(11'd0, d);
    checks++; if (d !== exp_status(0)) begin failures++; $display("FAIL mid_status: got %h want %h", d, exp_status(0)); end
    checks++; if (leds !== '0) begin failures++; $display("FAIL mid_leds: got %h want 0", leds); end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_rx_overflow();
    test_tx_overflow();
    test_irq();
    test_leds_ram();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tiny1_mmio_hub.md
# tiny1_mmio_hub

Memory-mapped I/O hub between the tiny1 core's memory port and the RAM/UART/LED resources of the tiny1 SoC. Bit 15 of the core address steers each access to RAM (passthrough) or to the hub's register file. Adds parametrised RX/TX byte FIFOs in front of the UART, a write-readable GPIO/LED register of configurable width, sticky overflow flags, and a maskable, acknowledgeable IRQ.

## Interface
- RX_DEPTH, 8, RX FIFO depth in bytes; power of two, 2..64
- TX_DEPTH, 8, TX FIFO depth in bytes; power of two, 2..64
- GPIO_W, 8, LED register width, 1..16
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset; synchronous, active-low
- mem_addr  in  16  core address; bit 15 set = mmio, [10:0] = register index
- mem_data_o  in  16  core write data
- mem_wr / mem_rd  in  1  core write / read strobes
- mem_data_i  out  16  read data to core
- ram_data_i  in  16  RAM read data
- ram_we / ram_re  out  1  RAM strobes; equal to core strobes when bit 15 clear, else 0
- uart_din  in  8  received byte, valid while uart_valid
- uart_valid  in  1  UART holds a received byte
- uart_ready  in  1  UART transmitter idle
- uart_rd  out  1  one-cycle pulse consuming uart_din
- uart_wr  out  1  one-cycle pulse sending uart_out
- uart_out  out  8  byte to transmit
- irq  out  1  interrupt request to core
- irqack  in  1  interrupt acknowledge from core
- leds  out  GPIO_W  LED register

## Operation
- Register map (index = mem_addr[10:0]; unlisted indices read 0, writes ignored):
  - 0 STATUS (R): b0 rx_nonempty, b1 tx_notfull, b2 rx_ovf, b3 tx_ovf, b4 irq. (W): writing 1 to b2/b3 clears that flag.
  - 1 RX_DATA (R): {8'b0, head}; the read pops. Reading an empty FIFO returns 0 and leaves state unchanged.
  - 2 TX_DATA (W): pushes mem_data_o[7:0]. Writing a full FIFO drops the byte and sets tx_ovf.
  - 3 LEDS (R/W): bits [GPIO_W-1:0]
  - 4 IRQ_EN (R/W): b0 rx_nonempty, b1 tx_empty, b2 any overflow
  - 5 RX_COUNT (R): occupancy; 6 TX_COUNT (R): occupancy
- RX drain FSM (IDLE, ACK):
  - IDLE: if uart_valid, assert uart_rd for that cycle and go to ACK.
  - On that uart_rd cycle, uart_din is pushed if the FIFO is not full. If the FIFO is full, the byte is discarded and rx_ovf is set, so the UART never stalls.
  - ACK: wait one cycle for uart_valid to fall, then return to IDLE.
- TX FSM (IDLE, SEND, HOLD):
  - IDLE: if the FIFO is not empty and uart_ready, go to SEND.
  - SEND: uart_out = head, uart_wr = 1, pop; go to HOLD.
  - HOLD: one cycle; then IDLE.
  - uart_out holds the last sent byte otherwise.
- FIFO rules:
  - Pointers wrap modulo depth.
  - A simultaneous push and pop in one cycle is legal on any non-full, non-empty FIFO; occupancy is unchanged.
  - Pop of an empty FIFO has no effect.
  - A push to a full RX FIFO with a simultaneous pop is accepted.
- IRQ:
  - cond = (rx_nonempty & en0) | (tx_empty & en1) | ((rx_ovf|tx_ovf) & en2)
  - Each cycle, irq <= cond, except: on an irqack cycle irq <= 0 and is held 0 the following cycle. It re-asserts on the second cycle if cond is still true.

## Timing
- Reset (rst low at posedge) clears:
  - FIFOs, flags, FSMs (to IDLE), leds, IRQ_EN, irq, mem_data_i register, uart_out
  - uart_rd and uart_wr are 0 during reset.
- RAM path: ram_we/ram_re are combinational. mem_data_i = ram_data_i when the registered mmio flag of the previous access is 0.
- MMIO read: data is registered and presented on mem_data_i in the cycle after mem_rd. The mux select is the mmio flag registered with the read.
- MMIO write: takes effect at the posedge where mem_wr is sampled. A LEDS write is visible on leds the next cycle.
- RX_DATA pop occurs at the mem_rd posedge. RX_COUNT read the following cycle reflects the pop.
- RX latency: uart_valid rising to RX_COUNT increment = 1 cycle. Maximum RX acceptance rate is one byte per 2 cycles.
- TX: a TX_DATA write reaches uart_wr at the earliest 2 cycles later (push, IDLE->SEND).
- Reset asserted mid-transfer aborts the FSMs immediately. In-flight bytes are lost, and no uart_rd/uart_wr is emitted in the reset cycle.

## Test plan
- Reset, then read STATUS -> 0x0002; leds = 0; irq = 0; uart_rd = uart_wr = 0.
- Feed 3 UART bytes 0x41, 0x42, 0x43 -> RX_COUNT = 3. Three RX_DATA reads return 0x0041, 0x0042, 0x0043. A fourth read returns 0 and STATUS b0 = 0.
- Feed RX_DEPTH+2 bytes with no reads -> RX_COUNT = RX_DEPTH and STATUS b2 = 1. Writing STATUS = 0x0004 clears b2.
- Hold uart_ready = 0 and write TX_DEPTH+1 bytes -> tx_ovf = 1 and TX_COUNT = TX_DEPTH. Release uart_ready -> exactly TX_DEPTH uart_wr pulses, bytes sent in order, each pulse 1 cycle wide.
- IRQ_EN = 1, one RX byte -> irq = 1 within 2 cycles. Pulse irqack -> irq = 0 for 2 cycles, then re-asserts. Read RX_DATA, then ack -> irq stays 0.
- Write LEDS 0x00A5 and read it back -> leds = 0xA5 (GPIO_W = 8). A core access with bit 15 clear asserts ram_we with no mmio side effect.
